// File: rtl/axi_arb_pkg.sv
// Shared types for the per-slave AXI transaction arbiter: FSM states,
// arbitration direction and the "no master" index encoding.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_RD,
        DATA_RD,
        ADDR_WR,
        RESP_WR
    } arb_state_t;

    typedef enum logic {
        READ,
        WRITE
    } dir_t;

    localparam int IDX_NONE = 0;

    // Width of a binary master index; a single master still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from ptr_i+1, wrapping at
// NUM_M-1, and returns the first requester as both one-hot and binary index.
module rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_M = 3,
    parameter int PW    = idx_width(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic             valid_o,
    output logic [NUM_M-1:0] winner_oh_o,
    output logic [PW-1:0]    winner_idx_o
);

    always_comb begin
        logic [PW-1:0] cand;
        valid_o      = 1'b0;
        winner_idx_o = '0;
        winner_oh_o  = '0;
        cand         = ptr_i;
        // Explicit wrap compare so non-power-of-two master counts rotate correctly.
        for (int i = 0; i < NUM_M; i++) begin
            cand = (cand == PW'(NUM_M - 1)) ? '0 : cand + PW'(1);
            if (!valid_o && req_i[cand]) begin
                valid_o      = 1'b1;
                winner_idx_o = cand;
            end
        end
        if (valid_o) begin
            winner_oh_o[winner_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_slave_rr_arbiter.sv
// Per-slave arbiter: round-robin within each direction, read/write alternation
// between directions, grant locked for a whole transaction, watchdog release.
module axi_slave_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M       = 3,
    parameter int MIDX_BITS   = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_M-1:0]     ar_req,
    input  logic [NUM_M-1:0]     aw_req,
    input  logic                 arready_s,
    input  logic                 awready_s,
    input  logic                 rvalid_s,
    input  logic                 rlast_s,
    input  logic                 bvalid_s,
    input  logic [NUM_M-1:0]     rready_m,
    input  logic [NUM_M-1:0]     bready_m,
    output logic [NUM_M-1:0]     grant_rd,
    output logic [NUM_M-1:0]     grant_wr,
    output logic [MIDX_BITS-1:0] r_idx,
    output logic [MIDX_BITS-1:0] w_idx,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int PW    = idx_width(NUM_M);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_t       state_q, state_d;
    dir_t             last_dir_q, last_dir_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [NUM_M-1:0] goh_q, goh_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    logic             rd_valid, wr_valid;
    logic [NUM_M-1:0] rd_win_oh, wr_win_oh;
    logic [PW-1:0]    rd_win_idx, wr_win_idx;
    logic             progress, wd_fire, rd_phase, wr_phase;

    rr_pick #(.NUM_M(NUM_M)) u_pick_rd (
        .req_i        (ar_req),
        .ptr_i        (rd_ptr_q),
        .valid_o      (rd_valid),
        .winner_oh_o  (rd_win_oh),
        .winner_idx_o (rd_win_idx)
    );

    rr_pick #(.NUM_M(NUM_M)) u_pick_wr (
        .req_i        (aw_req),
        .ptr_i        (wr_ptr_q),
        .valid_o      (wr_valid),
        .winner_oh_o  (wr_win_oh),
        .winner_idx_o (wr_win_idx)
    );

    assign wd_fire = (TIMEOUT_CYC != 0) && (state_q != IDLE)
                     && (wd_q == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        gidx_d     = gidx_q;
        goh_d      = goh_q;
        progress   = 1'b0;

        case (state_q)
            IDLE: begin
                // Read wins when it is alone or when the last grant was a write.
                if (rd_valid && (!wr_valid || last_dir_q == WRITE)) begin
                    state_d    = ADDR_RD;
                    gidx_d     = rd_win_idx;
                    goh_d      = rd_win_oh;
                    rd_ptr_d   = rd_win_idx;
                    last_dir_d = READ;
                end else if (wr_valid) begin
                    state_d    = ADDR_WR;
                    gidx_d     = wr_win_idx;
                    goh_d      = wr_win_oh;
                    wr_ptr_d   = wr_win_idx;
                    last_dir_d = WRITE;
                end
            end
            ADDR_RD: begin
                if (arready_s && ar_req[gidx_q]) begin
                    state_d  = DATA_RD;
                    progress = 1'b1;
                end else if (!ar_req[gidx_q]) begin
                    state_d = IDLE;
                end
            end
            DATA_RD: begin
                if (rvalid_s && rready_m[gidx_q]) begin
                    progress = 1'b1;
                    if (rlast_s) begin
                        state_d = IDLE;
                    end
                end
            end
            ADDR_WR: begin
                if (awready_s && aw_req[gidx_q]) begin
                    state_d  = RESP_WR;
                    progress = 1'b1;
                end else if (!aw_req[gidx_q]) begin
                    state_d = IDLE;
                end
            end
            RESP_WR: begin
                if (bvalid_s && bready_m[gidx_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (TIMEOUT_CYC == 0 || state_q == IDLE || progress) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + CNT_W'(1);
        end

        // A hung slave is released even if it completes in the same cycle.
        if (wd_fire) begin
            state_d = IDLE;
            wd_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_dir_q <= WRITE;
            rd_ptr_q   <= PW'(NUM_M - 1);
            wr_ptr_q   <= PW'(NUM_M - 1);
            gidx_q     <= '0;
            goh_q      <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            gidx_q     <= gidx_d;
            goh_q      <= goh_d;
            wd_q       <= wd_d;
        end
    end

    assign rd_phase    = (state_q == ADDR_RD) || (state_q == DATA_RD);
    assign wr_phase    = (state_q == ADDR_WR) || (state_q == RESP_WR);
    assign busy        = (state_q != IDLE);
    assign timeout_err = wd_fire;
    assign grant_rd    = rd_phase ? goh_q : '0;
    assign grant_wr    = wr_phase ? goh_q : '0;
    assign r_idx       = rd_phase ? MIDX_BITS'(gidx_q) + MIDX_BITS'(1) : MIDX_BITS'(IDX_NONE);
    assign w_idx       = wr_phase ? MIDX_BITS'(gidx_q) + MIDX_BITS'(1) : MIDX_BITS'(IDX_NONE);

endmodule

// File: tb/tb_axi_slave_rr_arbiter.sv
// Directed bench for axi_slave_rr_arbiter: a transaction table for fairness and
// alternation, plus hand sequences for stalls, watchdog, reset and dropped requests.
module tb_axi_slave_rr_arbiter;

    localparam int NUM_M = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NUM_M-1:0] ar_req = '0, aw_req = '0, rready_m = '0, bready_m = '0;
    logic             arready_s = 1'b0, awready_s = 1'b0;
    logic             rvalid_s = 1'b0, rlast_s = 1'b0, bvalid_s = 1'b0;

    logic [NUM_M-1:0] grant_rd, grant_wr, wd_grant_rd, wd_grant_wr;
    logic [1:0]       r_idx, w_idx, wd_r_idx, wd_w_idx;
    logic             busy, timeout_err, wd_busy, wd_timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    axi_slave_rr_arbiter #(.NUM_M(NUM_M), .MIDX_BITS(2), .TIMEOUT_CYC(256)) dut (
        .clk(clk), .rst(rst), .ar_req(ar_req), .aw_req(aw_req),
        .arready_s(arready_s), .awready_s(awready_s), .rvalid_s(rvalid_s),
        .rlast_s(rlast_s), .bvalid_s(bvalid_s), .rready_m(rready_m), .bready_m(bready_m),
        .grant_rd(grant_rd), .grant_wr(grant_wr), .r_idx(r_idx), .w_idx(w_idx),
        .busy(busy), .timeout_err(timeout_err)
    );

    // Short-watchdog instance on the same stimulus, only inspected in the timeout sequence.
    axi_slave_rr_arbiter #(.NUM_M(NUM_M), .MIDX_BITS(2), .TIMEOUT_CYC(8)) dut_wd (
        .clk(clk), .rst(rst), .ar_req(ar_req), .aw_req(aw_req),
        .arready_s(arready_s), .awready_s(awready_s), .rvalid_s(rvalid_s),
        .rlast_s(rlast_s), .bvalid_s(bvalid_s), .rready_m(rready_m), .bready_m(bready_m),
        .grant_rd(wd_grant_rd), .grant_wr(wd_grant_wr), .r_idx(wd_r_idx), .w_idx(wd_w_idx),
        .busy(wd_busy), .timeout_err(wd_timeout_err)
    );

    typedef struct {
        logic [2:0] ar;
        logic [2:0] aw;
        logic [2:0] egr;
        logic [2:0] egw;
        logic [1:0] eri;
        logic [1:0] ewi;
        int         beats;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] egr, input logic [2:0] egw,
                         input logic [1:0] eri, input logic [1:0] ewi, input logic eb);
        n_checks++;
        if ({grant_rd, grant_wr, r_idx, w_idx, busy} === {egr, egw, eri, ewi, eb}
            && !(grant_rd != 0 && grant_wr != 0)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got grd=%b gwr=%b r_idx=%0d w_idx=%0d busy=%b, want grd=%b gwr=%b r_idx=%0d w_idx=%0d busy=%b",
                     name, grant_rd, grant_wr, r_idx, w_idx, busy, egr, egw, eri, ewi, eb);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic do_reset(input logic [2:0] ar, input logic [2:0] aw);
        rst = 1'b0;
        ar_req = '0; aw_req = '0; rready_m = '0; bready_m = '0;
        arready_s = 0; awready_s = 0; rvalid_s = 0; rlast_s = 0; bvalid_s = 0;
        tick();
        ar_req = ar;
        aw_req = aw;
        tick();
        rst = 1'b1;
    endtask

    task automatic complete_read(input int beats);
        arready_s = 1'b1;
        tick();
        arready_s = 1'b0;
        rready_m  = '1;
        rvalid_s  = 1'b1;
        for (int b = 1; b <= beats; b++) begin
            rlast_s = (b == beats);
            tick();
        end
        rvalid_s = 1'b0;
        rlast_s  = 1'b0;
    endtask

    task automatic complete_write();
        awready_s = 1'b1;
        tick();
        awready_s = 1'b0;
        bready_m  = '1;
        bvalid_s  = 1'b1;
        tick();
        bvalid_s = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        // Round-robin order and read/write alternation, one transaction per row.
        tbl[0] = '{ar:3'b111, aw:3'b000, egr:3'b001, egw:3'b000, eri:2'd1, ewi:2'd0, beats:4};
        tbl[1] = '{ar:3'b111, aw:3'b000, egr:3'b010, egw:3'b000, eri:2'd2, ewi:2'd0, beats:1};
        tbl[2] = '{ar:3'b111, aw:3'b000, egr:3'b100, egw:3'b000, eri:2'd3, ewi:2'd0, beats:1};
        tbl[3] = '{ar:3'b111, aw:3'b000, egr:3'b001, egw:3'b000, eri:2'd1, ewi:2'd0, beats:1};
        tbl[4] = '{ar:3'b001, aw:3'b010, egr:3'b000, egw:3'b010, eri:2'd0, ewi:2'd2, beats:0};
        tbl[5] = '{ar:3'b001, aw:3'b010, egr:3'b001, egw:3'b000, eri:2'd1, ewi:2'd0, beats:1};
        tbl[6] = '{ar:3'b000, aw:3'b101, egr:3'b000, egw:3'b100, eri:2'd0, ewi:2'd3, beats:0};
        tbl[7] = '{ar:3'b110, aw:3'b101, egr:3'b010, egw:3'b000, eri:2'd2, ewi:2'd0, beats:2};
        tbl[8] = '{ar:3'b110, aw:3'b101, egr:3'b000, egw:3'b001, eri:2'd0, ewi:2'd1, beats:0};

        tick();
        check("reset_outputs", 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
        check_bit("reset_timeout_err", timeout_err, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            ar_req = tbl[i].ar;
            aw_req = tbl[i].aw;
            tick();
            check($sformatf("txn%0d_grant", i), tbl[i].egr, tbl[i].egw, tbl[i].eri, tbl[i].ewi, 1'b1);
            if (tbl[i].egr != 3'b000) begin
                arready_s = 1'b1;
                tick();
                arready_s = 1'b0;
                check($sformatf("txn%0d_data_phase", i), tbl[i].egr, 3'b000, tbl[i].eri, 2'd0, 1'b1);
                rready_m = '1;
                rvalid_s = 1'b1;
                for (int b = 1; b <= tbl[i].beats; b++) begin
                    rlast_s = (b == tbl[i].beats);
                    tick();
                    if (b < tbl[i].beats)
                        check($sformatf("txn%0d_beat%0d", i, b), tbl[i].egr, 3'b000, tbl[i].eri, 2'd0, 1'b1);
                end
                rvalid_s = 1'b0;
                rlast_s  = 1'b0;
            end else begin
                complete_write();
            end
            check($sformatf("txn%0d_release", i), 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
            $display("txn %0d: ar=%b aw=%b r_idx=%0d w_idx=%0d", i, tbl[i].ar, tbl[i].aw, tbl[i].eri, tbl[i].ewi);
        end

        // Read and write pending together straight out of reset.
        do_reset(3'b001, 3'b010);
        tick();
        check("tie_read_first", 3'b001, 3'b000, 2'd1, 2'd0, 1'b1);
        complete_read(1);
        check("tie_read_done", 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
        tick();
        check("tie_write_next", 3'b000, 3'b010, 2'd0, 2'd2, 1'b1);
        complete_write();
        check("tie_write_done", 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
        $display("txn tie: read m0 then write m1");

        // Slow AWREADY and back-pressured B channel on master 2.
        do_reset(3'b000, 3'b100);
        tick();
        check("stall_grant", 3'b000, 3'b100, 2'd0, 2'd3, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("stall_aw_%0d", c), 3'b000, 3'b100, 2'd0, 2'd3, 1'b1);
        end
        awready_s = 1'b1;
        tick();
        awready_s = 1'b0;
        aw_req    = '0;
        bvalid_s  = 1'b1;
        bready_m  = 3'b011;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_b_%0d", c), 3'b000, 3'b100, 2'd0, 2'd3, 1'b1);
        end
        bready_m = 3'b111;
        tick();
        bvalid_s = 1'b0;
        check("stall_b_done", 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
        $display("txn stall: write m2 w_idx=3 held through stalls");

        // Watchdog: slave accepts the address and then never returns data.
        do_reset(3'b001, 3'b000);
        tick();
        check_bit("wd_granted", wd_busy, 1'b1);
        arready_s = 1'b1;
        tick();
        arready_s = 1'b0;
        ar_req    = '0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_bit($sformatf("wd_quiet_%0d", c), wd_timeout_err, 1'b0);
        end
        tick();
        check_bit("wd_pulse", wd_timeout_err, 1'b1);
        check_bit("wd_busy_at_pulse", wd_busy, 1'b1);
        tick();
        check_bit("wd_pulse_ends", wd_timeout_err, 1'b0);
        check_bit("wd_released", wd_busy, 1'b0);
        check_bit("wd_grant_cleared", |wd_grant_rd, 1'b0);
        check("wd_long_timeout_still_busy", 3'b001, 3'b000, 2'd1, 2'd0, 1'b1);
        $display("txn watchdog: timeout_err after 8 stalled counts");

        // Reset in the middle of a read burst.
        do_reset(3'b111, 3'b000);
        tick();
        check("rst_mid_first", 3'b001, 3'b000, 2'd1, 2'd0, 1'b1);
        complete_read(1);
        tick();
        check("rst_mid_second", 3'b010, 3'b000, 2'd2, 2'd0, 1'b1);
        arready_s = 1'b1;
        tick();
        arready_s = 1'b0;
        rready_m  = '1;
        rvalid_s  = 1'b1;
        tick();
        check("rst_mid_beat1", 3'b010, 3'b000, 2'd2, 2'd0, 1'b1);
        rst = 1'b0;
        #2;
        check("rst_mid_async_clear", 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
        rvalid_s = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_ptr_reset", 3'b001, 3'b000, 2'd1, 2'd0, 1'b1);
        complete_read(1);
        ar_req = '0;
        $display("txn reset_mid: pointers back to master 0");

        // Read request withdrawn before ARREADY, pending write then served.
        do_reset(3'b010, 3'b001);
        tick();
        check("drop_grant", 3'b010, 3'b000, 2'd2, 2'd0, 1'b1);
        ar_req = 3'b000;
        tick();
        check("drop_idle", 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
        check_bit("drop_no_timeout", timeout_err, 1'b0);
        tick();
        check("drop_write_next", 3'b000, 3'b001, 2'd0, 2'd1, 1'b1);
        complete_write();
        check("drop_write_done", 3'b000, 3'b000, 2'd0, 2'd0, 1'b0);
        $display("txn drop: read m1 withdrawn, write m0 granted");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
